window_buffer_3x3: RTL and testbench

//  Upstream feeder of the 3x3 Sobel convolution stage. Accepts a raster-order pixel stream
//  (one PIX_W pixel per beat), stores the two previous image lines in internal line buffers,
//  and emits one packed 3x3 neighbourhood per pixel once a full window exists. Output packing

---
 rtl/window_buffer_3x3.sv | 137 +++++++++++++
 tb/tb_window_buffer_3x3.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_buffer_3x3.sv
// 3x3 sliding-window generator: two line buffers plus a 3x3 register window over a raster stream.
// Optional WINDOW_BUFFER_SOF_EN adds i_sof to resynchronise framing on a start-of-frame pixel.
module window_buffer_3x3 #(
    parameter int unsigned IMG_WIDTH  = 512,
    parameter int unsigned IMG_HEIGHT = 512,
    parameter int unsigned PIX_W      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    input  logic [PIX_W-1:0]     i_data,
`ifdef WINDOW_BUFFER_SOF_EN
    input  logic                 i_sof,
`endif
    output logic                 o_ready,
    input  logic                 i_ready,
    output logic [9*PIX_W-1:0]   o_data,
    output logic                 o_valid,
    output logic                 o_frame_done
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    localparam logic [0:0] FILL   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [PIX_W-1:0] lb0 [IMG_WIDTH];
    logic [PIX_W-1:0] lb1 [IMG_WIDTH];

    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] win_d [9];
    logic [9*PIX_W-1:0] win_pack;

    logic [CW-1:0] col_q, col_d, col_eff;
    logic [RW-1:0] row_q, row_d, row_eff;
    logic [0:0]    state_q, state_d, state_eff;

    logic accept, consume, sof, col_wrap, last, emit;
    logic [PIX_W-1:0] top, mid;

    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;
    assign consume = o_valid && i_ready;

`ifdef WINDOW_BUFFER_SOF_EN
    assign sof = i_sof;
`else
    assign sof = 1'b0;
`endif

    // A start-of-frame pixel is processed as if it sat at row 0, col 0 in FILL.
    always_comb begin
        col_eff   = sof ? '0 : col_q;
        row_eff   = sof ? '0 : row_q;
        state_eff = sof ? FILL : state_q;
        col_wrap  = (col_eff == COL_LAST);
        last      = col_wrap && (row_eff == ROW_LAST);
        emit      = accept && (state_eff == ACTIVE) && (col_eff >= COL_TWO);
        top       = lb0[col_eff];
        mid       = lb1[col_eff];
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[3*r]     = win_q[3*r+1];
            win_d[3*r+1]   = win_q[3*r+2];
        end
        win_d[2] = top;
        win_d[5] = mid;
        win_d[8] = i_data;
        win_pack = '0;
        for (int i = 0; i < 9; i++) begin
            win_pack[PIX_W*i +: PIX_W] = win_d[i];
        end
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        if (accept) begin
            col_d = col_wrap ? '0 : col_eff + CW'(1);
            row_d = row_eff;
            if (col_wrap) begin
                row_d = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
            end
            state_d = state_eff;
            if (last) begin
                state_d = FILL;
            end else if (state_eff == FILL && row_eff == ROW_ONE && col_wrap) begin
                state_d = ACTIVE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= FILL;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            state_q      <= state_d;
            o_frame_done <= accept && last;
            if (accept) begin
                win_q <= win_d;
            end
            if (emit) begin
                o_valid <= 1'b1;
                o_data  <= win_pack;
            end else if (consume) begin
                o_valid <= 1'b0;
            end
        end
    end

    // Line buffers need no reset: every entry is rewritten before it is read.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb0[col_eff] <= lb1[col_eff];
            lb1[col_eff] <= i_data;
        end
    end

endmodule

// File: tb/tb_window_buffer_3x3.sv
// Self-checking bench for window_buffer_3x3 (4x4 image) against a frame-array reference model.
// Define WINDOW_BUFFER_SOF_EN for both bench and RTL to exercise the start-of-frame input.
module tb_window_buffer_3x3;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_valid = 1'b0;
    logic [PW-1:0] i_data = '0;
    logic          i_ready = 1'b1;
    logic          sof = 1'b0;
    logic          o_ready;
    logic [9*PW-1:0] o_data;
    logic          o_valid;
    logic          o_frame_done;

    window_buffer_3x3 #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PIX_W     (PW)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_valid     (i_valid),
        .i_data      (i_data),
`ifdef WINDOW_BUFFER_SOF_EN
        .i_sof       (sof),
`endif
        .o_ready     (o_ready),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: pixels land in a frame image by arrival index; every pixel
    // with row>=2 and col>=2 yields the 3x3 neighbourhood ending at it.
    logic [PW-1:0]   img [H][W];
    int              m_n = 0;
    logic            m_valid = 1'b0;
    logic [71:0]     m_data = '0;
    logic            m_fd = 1'b0;
    logic            m_acc = 1'b0;
    int              m_emitted = 0;
    int              cyc = 0;
    logic [71:0]     got_q [$];
    int              fd_q [$];

    always @(negedge clk) begin
        int r, c;
        cyc++;
        if (!rst_n) begin
            m_n = 0; m_valid = 1'b0; m_data = '0; m_fd = 1'b0; m_acc = 1'b0; m_emitted = 0;
        end else begin
            check("o_valid", 72'(o_valid), 72'(m_valid));
            check("o_frame_done", 72'(o_frame_done), 72'(m_fd));
            check("o_ready", 72'(o_ready), 72'(!m_valid || i_ready));
            if (m_valid) check("o_data", o_data, m_data);
            if (o_valid && i_ready) got_q.push_back(o_data);
            if (o_frame_done) fd_q.push_back(cyc);
            m_acc = i_valid && (!m_valid || i_ready);
            m_fd  = 1'b0;
            if (m_acc) begin
`ifdef WINDOW_BUFFER_SOF_EN
                if (sof) m_n = 0;
`endif
                r = m_n / W;
                c = m_n % W;
                img[r][c] = i_data;
                if (r >= 2 && c >= 2) begin
                    for (int rr = 0; rr < 3; rr++)
                        for (int cc = 0; cc < 3; cc++)
                            m_data[PW*(3*rr+cc) +: PW] = img[r-2+rr][c-2+cc];
                    m_valid = 1'b1;
                    m_emitted++;
                end else if (m_valid && i_ready) begin
                    m_valid = 1'b0;
                end
                m_fd = (m_n == W*H - 1);
                m_n  = (m_n + 1) % (W*H);
            end else if (m_valid && i_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Hand-computed windows for pixel value 4*row+col.
    int exp_win [4][9] = '{'{0, 1, 2, 4, 5, 6, 8, 9, 10},
                           '{1, 2, 3, 5, 6, 7, 9, 10, 11},
                           '{4, 5, 6, 8, 9, 10, 12, 13, 14},
                           '{5, 6, 7, 9, 10, 11, 13, 14, 15}};

    function automatic logic [71:0] pack9(input int k);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[PW*i +: PW] = PW'(exp_win[k][i]);
        return v;
    endfunction

    task automatic check_windows(input string tag, input int nwin);
        check({tag, "_win_count"}, 72'(got_q.size()), 72'(nwin));
        for (int i = 0; i < nwin && i < got_q.size(); i++)
            check({tag, "_window"}, got_q[i], pack9(i % 4));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; sof = 1'b0; i_data = '0;
        #1;
        check("reset_o_valid", 72'(o_valid), 72'(0));
        check("reset_o_data", o_data, 72'(0));
        check("reset_o_frame_done", 72'(o_frame_done), 72'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        fd_q.delete();
    endtask

    // Streams npix pixels (value = arrival index mod 16) with random valid/ready duty.
    task automatic stream(input int npix, input int vpct, input int rpct, input bit first_sof,
                          input bit stall);
        int k = 0;
        int guard = 0;
        int stalled = 0;
        while (k < npix) begin
            i_valid = ($urandom_range(99) < vpct);
            i_data  = PW'(k % (W*H));
            i_ready = ($urandom_range(99) < rpct);
            sof     = first_sof && (k == 0);
            if (stall && m_emitted >= 1 && stalled < 6) begin
                i_ready = 1'b0;
                stalled++;
            end
            @(negedge clk);
            #1;
            if (m_acc) k++;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 5000) begin
                check("stream_timeout", 72'(k), 72'(npix));
                break;
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        sof     = 1'b0;
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        #2;
        // Single frame, full throughput.
        do_reset();
        stream(16, 100, 100, 1'b0, 1'b0);
        drain();
        check_windows("s1", 4);
        check("s1_frame_done_count", 72'(fd_q.size()), 72'(1));

        // Backpressure after first window.
        do_reset();
        stream(16, 100, 100, 1'b0, 1'b1);
        drain();
        check_windows("s2", 4);

        // Two back-to-back frames.
        do_reset();
        stream(32, 100, 100, 1'b0, 1'b0);
        drain();
        check_windows("s3", 8);
        check("s3_frame_done_count", 72'(fd_q.size()), 72'(2));
        if (fd_q.size() == 2) check("s3_frame_done_gap", 72'(fd_q[1] - fd_q[0]), 72'(16));

        // Random input gaps.
        do_reset();
        stream(16, 50, 100, 1'b0, 1'b0);
        drain();
        check_windows("s4", 4);

        // Reset mid row 2 while a window is pending, then a clean frame.
        do_reset();
        stream(11, 100, 100, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("s5_async_o_valid", 72'(o_valid), 72'(0));
        check("s5_async_o_frame_done", 72'(o_frame_done), 72'(0));
        check("s5_async_o_data", o_data, 72'(0));
        do_reset();
        stream(16, 100, 100, 1'b0, 1'b0);
        drain();
        check_windows("s5", 4);

`ifdef WINDOW_BUFFER_SOF_EN
        // Truncated frame, then a start-of-frame restart.
        do_reset();
        stream(6, 100, 100, 1'b0, 1'b0);
        stream(16, 100, 100, 1'b1, 1'b0);
        drain();
        check_windows("s6", 4);
        check("s6_frame_done_count", 72'(fd_q.size()), 72'(1));
`endif

        // Random valid and ready over three frames.
        do_reset();
        stream(48, 60, 70, 1'b0, 1'b0);
        drain();
        check_windows("s7", 12);
        check("s7_frame_done_count", 72'(fd_q.size()), 72'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
